run_ctrl: RTL and testbench

Run sequencer and data-memory arbiter that sits between a host and the 9-bit-instruction core. It parks the core in start while idle and shares the core's data memory port with host preload/readback traffic. On a host run request it releases start after a minimum hold and counts execution cycles until the core's Done. A watchdog ends runaway programs.

---
 rtl/run_ctrl.sv | 138 +++++++++++++
 tb/tb_run_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Run sequencer and data-memory arbiter between a host and the core.
// Optional RUN_CTRL_TIMEOUT_EN enables the watchdog; otherwise the cycle counter saturates.
module run_ctrl #(
   parameter int unsigned START_CYCLES = 2,
   parameter int unsigned TIMEOUT      = 1023,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             RunReq,
   output logic             RunAck,
   output logic             Busy,
   output logic             RunDone,
   output logic             TimedOut,
   output logic [CNT_W-1:0] CycleCnt,
   output logic             CoreStart,
   input  logic             CoreDone,
   input  logic             HostReq,
   input  logic             HostWe,
   input  logic [7:0]       HostAddr,
   input  logic [7:0]       HostWdat,
   output logic             HostGnt,
   output logic             MemWen,
   output logic [7:0]       MemAddr,
   output logic [7:0]       MemWdat,
   input  logic [7:0]       MemRdat,
   output logic [7:0]       HostRdat
);

`ifdef RUN_CTRL_TIMEOUT_EN
   localparam bit TimeoutEn = 1'b1;
`else
   localparam bit TimeoutEn = 1'b0;
`endif

   localparam int unsigned HoldW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

   typedef enum logic [1:0] {StIdle, StHost, StStart, StRun} state_e;

   state_e             state_q, state_d;
   logic [HoldW-1:0]   hold_q, hold_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
   logic               timed_out_q, timed_out_d;
   logic               run_ack_q, run_ack_d;
   logic               run_done_q, run_done_d;
   logic               core_start_q, busy_q, host_gnt_q;

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      cnt_d       = cnt_q;
      cycle_cnt_d = cycle_cnt_q;
      timed_out_d = timed_out_q;
      run_ack_d   = 1'b0;
      run_done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (HostReq) begin
               state_d = StHost;
            end else if (RunReq) begin
               state_d     = StStart;
               run_ack_d   = 1'b1;
               timed_out_d = 1'b0;
               hold_d      = HoldW'(START_CYCLES - 1);
            end
         end
         StHost: begin
            if (!HostReq) state_d = StIdle;
         end
         StStart: begin
            if (hold_q == '0) begin
               state_d = StRun;
               cnt_d   = '0;
            end else begin
               hold_d = hold_q - HoldW'(1);
            end
         end
         StRun: begin
            if (CoreDone) begin
               cycle_cnt_d = cnt_q;
               run_done_d  = 1'b1;
               state_d     = StIdle;
            end else if (TimeoutEn && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
               cycle_cnt_d = CNT_W'(TIMEOUT);
               timed_out_d = 1'b1;
               run_done_d  = 1'b1;
               state_d     = StIdle;
            end else if (cnt_q != '1) begin
               // Saturation only matters when the watchdog is disabled
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q      <= StIdle;
         hold_q       <= '0;
         cnt_q        <= '0;
         cycle_cnt_q  <= '0;
         timed_out_q  <= 1'b0;
         run_ack_q    <= 1'b0;
         run_done_q   <= 1'b0;
         core_start_q <= 1'b1;
         busy_q       <= 1'b0;
         host_gnt_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         cnt_q        <= cnt_d;
         cycle_cnt_q  <= cycle_cnt_d;
         timed_out_q  <= timed_out_d;
         run_ack_q    <= run_ack_d;
         run_done_q   <= run_done_d;
         core_start_q <= (state_d != StRun);
         busy_q       <= (state_d == StStart) || (state_d == StRun);
         host_gnt_q   <= (state_d == StHost);
      end
   end

   assign RunAck    = run_ack_q;
   assign RunDone   = run_done_q;
   assign Busy      = busy_q;
   assign TimedOut  = timed_out_q;
   assign CycleCnt  = cycle_cnt_q;
   assign CoreStart = core_start_q;
   assign HostGnt   = host_gnt_q;

   // Host path to DMem is only live while the grant is held
   assign MemWen   = host_gnt_q & HostReq & HostWe;
   assign MemAddr  = host_gnt_q ? HostAddr : 8'h00;
   assign MemWdat  = host_gnt_q ? HostWdat : 8'h00;
   assign HostRdat = MemRdat;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: core/DMem models plus a run-result scoreboard.
module tb_run_ctrl;

   localparam int unsigned StartCycles = 2;
   localparam int unsigned Timeout     = 20;
   localparam int unsigned CntW        = 6;

   logic            Clk;
   logic            Rst_n;
   logic            RunReq;
   logic            RunAck;
   logic            Busy;
   logic            RunDone;
   logic            TimedOut;
   logic [CntW-1:0] CycleCnt;
   logic            CoreStart;
   logic            CoreDone;
   logic            HostReq;
   logic            HostWe;
   logic [7:0]      HostAddr;
   logic [7:0]      HostWdat;
   logic            HostGnt;
   logic            MemWen;
   logic [7:0]      MemAddr;
   logic [7:0]      MemWdat;
   logic [7:0]      MemRdat;
   logic [7:0]      HostRdat;

   run_ctrl #(
      .START_CYCLES(StartCycles),
      .TIMEOUT     (Timeout),
      .CNT_W       (CntW)
   ) dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .RunReq   (RunReq),
      .RunAck   (RunAck),
      .Busy     (Busy),
      .RunDone  (RunDone),
      .TimedOut (TimedOut),
      .CycleCnt (CycleCnt),
      .CoreStart(CoreStart),
      .CoreDone (CoreDone),
      .HostReq  (HostReq),
      .HostWe   (HostWe),
      .HostAddr (HostAddr),
      .HostWdat (HostWdat),
      .HostGnt  (HostGnt),
      .MemWen   (MemWen),
      .MemAddr  (MemAddr),
      .MemWdat  (MemWdat),
      .MemRdat  (MemRdat),
      .HostRdat (HostRdat)
   );

   typedef struct packed {
      logic [CntW-1:0] cnt;
      logic            to;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   done_after = -1;
   int   core_cycles = 0;
   logic [7:0] mem [256];

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // DMem model
   initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   always @(posedge Clk) if (MemWen) mem[MemAddr] <= MemWdat;
   assign MemRdat = mem[MemAddr];

   // Core model: raises Done in RUN cycle number done_after (counting from 0), -1 = never
   always @(negedge Clk) begin
      if (Busy && !CoreStart) begin
         if (core_cycles == done_after) CoreDone = 1'b1;
         core_cycles++;
      end else begin
         core_cycles = 0;
         CoreDone    = 1'b0;
      end
   end

   // Scoreboard consumer
   always @(negedge Clk) begin : mon
      exp_t e;
      if (Rst_n && RunDone) begin
         if (sb_q.size() == 0) begin
            check("rundone_unexpected", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("cyclecnt", 32'(CycleCnt), 32'(e.cnt));
            check("timedout", 32'(TimedOut), 32'(e.to));
         end
      end
   end

   task automatic wait_ack(input int limit);
      for (int i = 0; i < limit; i++) begin
         @(negedge Clk);
         if (RunAck) break;
      end
      check("runack_seen", 32'(RunAck), 32'd1);
   endtask

   task automatic wait_done(input int limit);
      for (int i = 0; i < limit; i++) begin
         @(negedge Clk);
         if (RunDone) break;
      end
      check("rundone_seen", 32'(RunDone), 32'd1);
   endtask

   task automatic push_exp(input int cnt, input logic to);
      exp_t e;
      e.cnt = CntW'(cnt);
      e.to  = to;
      sb_q.push_back(e);
   endtask

   initial begin
      Rst_n    = 1'b1;
      CoreDone = 1'b0;
      RunReq   = 1'b0;
      HostReq  = 1'b0;
      HostWe   = 1'b0;
      HostAddr = 8'h00;
      HostWdat = 8'h00;
      #3 Rst_n = 1'b0;
      repeat (2) @(negedge Clk);
      check("rst_corestart", 32'(CoreStart), 32'd1);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_ack", 32'(RunAck), 32'd0);
      check("rst_done", 32'(RunDone), 32'd0);
      check("rst_cyclecnt", 32'(CycleCnt), 32'd0);
      check("rst_gnt", 32'(HostGnt), 32'd0);
      Rst_n = 1'b1;

      // Basic run, Done after 9 RUN cycles
      @(negedge Clk);
      done_after = 9;
      push_exp(9, 1'b0);
      RunReq = 1'b1;
      wait_ack(4);
      check("ack_busy", 32'(Busy), 32'd1);
      check("start_hi", 32'(CoreStart), 32'd1);
      RunReq = 1'b0;
      @(negedge Clk);
      check("ack_pulse", 32'(RunAck), 32'd0);
      check("start_hold", 32'(CoreStart), 32'd1);
      @(negedge Clk);
      check("start_fall", 32'(CoreStart), 32'd0);
      wait_done(40);
      @(negedge Clk);
      check("idle_busy", 32'(Busy), 32'd0);
      check("done_pulse", 32'(RunDone), 32'd0);

      // Host wins over run request; write then read back
      HostReq  = 1'b1;
      HostWe   = 1'b1;
      HostAddr = 8'h10;
      HostWdat = 8'h5A;
      RunReq   = 1'b1;
      @(negedge Clk);
      check("gnt_rise", 32'(HostGnt), 32'd1);
      check("host_wins", 32'(RunAck), 32'd0);
      check("memwen", 32'(MemWen), 32'd1);
      check("memaddr", 32'(MemAddr), 32'h10);
      check("memwdat", 32'(MemWdat), 32'h5A);
      @(negedge Clk);
      HostWe = 1'b0;
      @(negedge Clk);
      check("rd_data", 32'(HostRdat), 32'h5A);
      check("memwen_rd", 32'(MemWen), 32'd0);
      check("host_hold_ack", 32'(RunAck), 32'd0);
      done_after = 3;
      push_exp(3, 1'b0);
      HostReq = 1'b0;
      @(negedge Clk);
      check("gnt_fall", 32'(HostGnt), 32'd0);
      check("ack_wait", 32'(RunAck), 32'd0);
      @(negedge Clk);
      check("ack_after_host", 32'(RunAck), 32'd1);
      RunReq = 1'b0;
      wait_done(30);

      // Host request held off during a run
      @(negedge Clk);
      done_after = 6;
      push_exp(6, 1'b0);
      RunReq = 1'b1;
      wait_ack(4);
      RunReq   = 1'b0;
      HostReq  = 1'b1;
      HostWe   = 1'b1;
      HostAddr = 8'h20;
      HostWdat = 8'hFF;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (RunDone) break;
         check("gnt_held", 32'(HostGnt), 32'd0);
         check("memwen_held", 32'(MemWen), 32'd0);
      end
      check("done_in_hostwait", 32'(RunDone), 32'd1);
      check("gnt_at_done", 32'(HostGnt), 32'd0);
      @(negedge Clk);
      check("gnt_after_idle", 32'(HostGnt), 32'd1);
      HostReq = 1'b0;
      HostWe  = 1'b0;
      @(negedge Clk);
      check("gnt_drop", 32'(HostGnt), 32'd0);

`ifdef RUN_CTRL_TIMEOUT_EN
      // Watchdog stop, then TimedOut cleared by next RunAck
      done_after = -1;
      push_exp(Timeout, 1'b1);
      RunReq = 1'b1;
      wait_ack(4);
      RunReq = 1'b0;
      wait_done(60);
      @(negedge Clk);
      check("timedout_hold", 32'(TimedOut), 32'd1);
      done_after = 5;
      push_exp(5, 1'b0);
      RunReq = 1'b1;
      wait_ack(4);
      check("timedout_clr", 32'(TimedOut), 32'd0);
      RunReq = 1'b0;
      wait_done(30);
`else
      // No watchdog: runs past TIMEOUT and the counter saturates
      done_after = 70;
      push_exp((1 << CntW) - 1, 1'b0);
      RunReq = 1'b1;
      wait_ack(4);
      RunReq = 1'b0;
      repeat (40) @(negedge Clk);
      check("busy_past_timeout", 32'(Busy), 32'd1);
      check("no_timedout", 32'(TimedOut), 32'd0);
      wait_done(60);
`endif

      // Back-to-back runs with RunReq held
      @(negedge Clk);
      done_after = 4;
      push_exp(4, 1'b0);
      push_exp(4, 1'b0);
      RunReq = 1'b1;
      wait_ack(4);
      wait_done(30);
      @(negedge Clk);
      check("b2b_ack", 32'(RunAck), 32'd1);
      RunReq = 1'b0;
      wait_done(30);

      // Asynchronous reset in the middle of RUN
      @(negedge Clk);
      done_after = -1;
      RunReq = 1'b1;
      wait_ack(4);
      RunReq = 1'b0;
      repeat (6) @(negedge Clk);
      check("pre_rst_start", 32'(CoreStart), 32'd0);
      #2 Rst_n = 1'b0;
      #1 check("async_start", 32'(CoreStart), 32'd1);
      @(negedge Clk);
      check("mid_rst_busy", 32'(Busy), 32'd0);
      check("mid_rst_done", 32'(RunDone), 32'd0);
      check("mid_rst_cnt", 32'(CycleCnt), 32'd0);
      check("mid_rst_to", 32'(TimedOut), 32'd0);
      Rst_n = 1'b1;
      repeat (3) @(negedge Clk);
      check("post_rst_busy", 32'(Busy), 32'd0);
      check("post_rst_start", 32'(CoreStart), 32'd1);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
